// File: rtl/dmem_bridge.sv
// Load/store bridge between the single-cycle core and a valid/ready memory bus.
// Stores are posted into a write FIFO; loads forward from it or go to the bus.
module dmem_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] memReadData,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data
);

  // state   | meaning
  // IDLE    | accept stores, forward loads, drain buffer in background
  // DRAIN   | load missed; flushing buffered stores before the read
  // RD_REQ  | read request on the bus
  // RD_WAIT | waiting for read response
  // RD_DONE | returning latched read data to the core for one cycle
  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, fwd_idx;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data, fwd_data;
  logic              full, empty, drain_en, push, pop, fwd_hit, latch_miss;

  assign full     = (count == CNT_W'(WBUF_DEPTH));
  assign empty    = (count == '0);
  assign drain_en = ((state == IDLE) || (state == DRAIN)) && !empty;
  assign pop      = drain_en && bus_req_ready;
  assign push     = MemWrite && (state == IDLE) && !full;

  // Walk oldest to youngest so the youngest matching word wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wb_addr[fwd_idx][ADDR_W-1:2] == memAddr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[fwd_idx];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    latch_miss    = 1'b0;
    memReadData   = '0;
    bus_req_valid = 1'b0;
    bus_req_we    = 1'b0;
    bus_req_addr  = '0;
    bus_req_wdata = '0;
    if (drain_en) begin
      bus_req_valid = 1'b1;
      bus_req_we    = 1'b1;
      bus_req_addr  = wb_addr[rd_ptr];
      bus_req_wdata = wb_data[rd_ptr];
    end
    case (state)
      IDLE: begin
        if (MemWrite) begin
          stall = full;
        end else if (MemRead) begin
          if (fwd_hit) begin
            memReadData = fwd_data;
          end else begin
            stall      = 1'b1;
            latch_miss = 1'b1;
            state_nxt  = empty ? RD_REQ : DRAIN;
          end
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (empty || ((count == CNT_W'(1)) && pop)) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_addr  = rd_addr;
        if (bus_req_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (bus_rsp_valid) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        memReadData = rd_data;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (latch_miss) rd_addr <= memAddr;
      if ((state == RD_WAIT) && bus_rsp_valid) rd_data <= bus_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr] <= memAddr;
      wb_data[wr_ptr] <= memWriteData;
    end
  end

endmodule
